uart_tx_cfg: RTL

Configurable UART transmitter and the successor to the fixed 8N1 transmitter. It serialises words taken from the TX FIFO over a valid/ready handshake. The data width is set at build time; the baud divisor, parity mode and stop-bit count are set at run time and latched per frame. It sits between the TX FIFO and the TX pin, gated by the host's RTS.

---
 rtl/uart_tx_cfg.sv | 136 +++++++++++++
 1 files changed

// File: rtl/uart_tx_cfg.sv
// Purpose: configurable UART transmitter with run-time divisor, parity and stop bits.
// Latency: the line drops to the start bit one clock after accept; the frame is div*(1+DATA_BITS+P+S) clocks.
// Backpressure: o_Ready is high only in idle with i_RTS set; a word is taken on i_Valid && o_Ready.
module uart_tx_cfg #(
  parameter int DATA_BITS = 8,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 i_Clock,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] i_Div,
  input  logic                 i_Parity_En,
  input  logic                 i_Parity_Odd,
  input  logic                 i_Two_Stop,
  input  logic                 i_RTS,
  input  logic                 i_Valid,
  input  logic [DATA_BITS-1:0] i_Data,
  output logic                 o_Ready,
  output logic                 o_TX_Active,
  output logic                 o_TX_Serial,
  output logic                 o_TX_Done
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state;
  logic [DIV_WIDTH-1:0] clk_cnt;
  logic [DIV_WIDTH-1:0] div_r;
  logic [DIV_WIDTH-1:0] div_clamped;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_en_r;
  logic                 par_bit_r;
  logic                 two_stop_r;
  logic                 stop_second;
  logic                 accept;
  logic                 bit_end;

  // Divisors below 2 would give zero- or one-clock bits; treat them as 2.
  always_comb begin
    div_clamped = i_Div;
    if (i_Div < DIV_WIDTH'(2)) div_clamped = DIV_WIDTH'(2);
  end

  assign o_Ready = (state == S_IDLE) && i_RTS && !rst;
  assign accept  = i_Valid && o_Ready;
  assign bit_end = (clk_cnt == div_r - DIV_WIDTH'(1));

  // Frame sequencer: latches the word and config on accept, then walks start/data/parity/stop.
  always_ff @(posedge i_Clock) begin
    if (rst) begin
      state       <= S_IDLE;
      clk_cnt     <= '0;
      div_r       <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      par_en_r    <= 1'b0;
      par_bit_r   <= 1'b0;
      two_stop_r  <= 1'b0;
      stop_second <= 1'b0;
      o_TX_Serial <= 1'b1;
      o_TX_Active <= 1'b0;
      o_TX_Done   <= 1'b0;
    end else begin
      o_TX_Done <= 1'b0;
      if (state == S_IDLE) begin
        if (accept) begin
          shreg       <= i_Data;
          div_r       <= div_clamped;
          par_en_r    <= i_Parity_En;
          // Parity is resolved at accept so later data/mode changes cannot leak in.
          par_bit_r   <= (^i_Data) ^ i_Parity_Odd;
          two_stop_r  <= i_Two_Stop;
          clk_cnt     <= '0;
          bit_idx     <= '0;
          stop_second <= 1'b0;
          state       <= S_START;
          o_TX_Serial <= 1'b0;
          o_TX_Active <= 1'b1;
        end
      end else if (!bit_end) begin
        clk_cnt <= clk_cnt + DIV_WIDTH'(1);
      end else begin
        clk_cnt <= '0;
        case (state)
          S_START: begin
            state       <= S_DATA;
            o_TX_Serial <= shreg[0];
          end
          S_DATA: begin
            if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
              if (par_en_r) begin
                state       <= S_PARITY;
                o_TX_Serial <= par_bit_r;
              end else begin
                state       <= S_STOP;
                o_TX_Serial <= 1'b1;
              end
            end else begin
              bit_idx     <= bit_idx + IDX_W'(1);
              shreg       <= shreg >> 1;
              o_TX_Serial <= shreg[1];
            end
          end
          S_PARITY: begin
            state       <= S_STOP;
            o_TX_Serial <= 1'b1;
          end
          S_STOP: begin
            if (two_stop_r && !stop_second) begin
              stop_second <= 1'b1;
            end else begin
              state       <= S_IDLE;
              o_TX_Serial <= 1'b1;
              o_TX_Active <= 1'b0;
              o_TX_Done   <= 1'b1;
            end
          end
          default: begin
            state       <= S_IDLE;
            o_TX_Serial <= 1'b1;
            o_TX_Active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
